byte_serial_subtractor: RTL and testbench
=========================================

# byte_serial_subtractor

Multi-cycle WIDTH-bit subtractor that computes minuend − subtrahend − borrow one 8-bit slice per clock, LSB slice first. It uses a single 8-bit borrow-lookahead slice, the subtracting counterpart of the 8-bit carry-lookahead adder. It sits in the arithmetic path wherever area matters more than latency. Operands enter through a valid/ready handshake; the result and flags leave through a second valid/ready handshake.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8; NSLICE = WIDTH/8
- clk_i  input  1  clock; all logic is rising-edge
- rst_ni  input  1  reset, asynchronous, active-low
- valid_i  input  1  operands valid
- ready_o  output  1  block can accept operands
- minuend_i  input  WIDTH  operand A
- subtrahend_i  input  WIDTH  operand B
- borrow_i  input  1  incoming borrow, subtracted at bit 0
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- difference_o  output  WIDTH  A − B − borrow_i, modulo 2^WIDTH
- borrow_o  output  1  unsigned borrow out; 1 iff A < B + borrow_i
- overflow_o  output  1  two's-complement overflow
- zero_o  output  1  difference_o == 0

## Operation
- FSM states and transitions:
  - IDLE to RUN on valid_i && ready_o.
  - RUN to DONE after slice NSLICE−1 is written.
  - DONE to IDLE on valid_o && ready_i.
- ready_o = (state == IDLE). valid_o = (state == DONE). Both are registered-state decodes.
- On accept: capture A and B into operand registers, set the borrow register to borrow_i, set the slice counter to 0, and clear the difference register.
- In RUN, each cycle, for k = slice counter:
  - Write difference[8k+7:8k] = A[8k+7:8k] − B[8k+7:8k] − borrow_reg.
  - Update borrow_reg with the slice borrow out.
  - Increment the counter.
- Slice arithmetic: diff = a + ~b + ~bin over 9 bits; bout = ~carry9.
- Flags, registered on entry to DONE:
  - borrow_o = final borrow_reg.
  - overflow_o = (A[W−1] ≠ B[W−1]) && (diff[W−1] ≠ A[W−1]).
  - zero_o = ~|difference.
- difference_o, borrow_o, overflow_o and zero_o stay stable from DONE entry until the next accept. They are not cleared on leaving DONE.
- valid_i while not IDLE is ignored. Operand inputs are sampled only at the accept edge.
- Reset, including mid-RUN or in DONE:
  - state goes to IDLE.
  - Counter, operand registers, borrow_reg, difference_o, borrow_o, overflow_o and zero_o all go to 0.
  - valid_o = 0 and ready_o = 1 while rst_ni is low and after it rises.
  - Any partial result is discarded.

## Timing
- Accept at edge T0. Slices are written at edges T1..T_NSLICE. valid_o rises after edge T_NSLICE, i.e. NSLICE cycles after accept (4 for WIDTH=32).
- The result handshake at edge Td returns the FSM to IDLE. ready_o is high in the following cycle; the earliest next accept is edge Td+1.
- Minimum initiation interval: NSLICE+2 cycles.
- Backpressure: valid_o and all result outputs are held indefinitely while ready_i = 0.
- The slice counter is exactly log2ceil(NSLICE) bits wide, minimum 1. It does not wrap in normal operation and is reset on each accept.

## Structure
- Shared package arith_pkg:
  - BYTE_W = 8.
  - Enum sub_state_t {IDLE, RUN, DONE}.
- Sub-module borrow_lookahead_subtractor_8b, purely combinational:
  - Inputs: minuend_i[7:0], subtrahend_i[7:0], borrow_i.
  - Outputs: difference_o[7:0], borrow_o.
  - Borrow chain uses generate/propagate lookahead: g = ~a & b, p = ~(a ^ b).
  - Instantiated once in the top block.
- Top block: FSM, slice counter, operand/difference registers, and slice mux/demux via indexed part-select.

## Test plan
- Basic: A=0x0000_0005, B=0x0000_0003, borrow_i=0. Expect difference_o=0x0000_0002 with borrow_o=0, overflow_o=0, zero_o=0, and valid_o high exactly 4 cycles after the accept edge.
- Wrap-around: A=0x0000_0000, B=0x0000_0001. Expect 0xFFFF_FFFF with borrow_o=1 and overflow_o=0, confirming the borrow ripples across all 4 slices.
- Signed overflow: A=0x8000_0000, B=0x0000_0001. Expect 0x7FFF_FFFF with overflow_o=1 and borrow_o=0.
- Borrow-in and zero:
  - A=0x1234_5678, B=0x1234_5677, borrow_i=1: expect 0x0000_0000 with zero_o=1 and borrow_o=0.
  - Same operands with borrow_i=0: expect 0x0000_0001.
- Backpressure and busy:
  - Hold ready_i=0 for 5 cycles in DONE: outputs must stay stable.
  - Pulse valid_i with new operands during RUN: it is ignored (ready_o=0), and the original result is returned.
- Reset mid-operation:
  - Deassert rst_ni after 2 slices of 0xFFFF_FFFF − 0x0000_0001. Expect immediately valid_o=0, ready_o=1 and difference_o=0.
  - Next operation 0x10 − 0x01 returns 0x0000_000F.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: slice width and the serial-subtractor state encoding.
package arith_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

endpackage

// File: rtl/borrow_lookahead_subtractor_8b.sv
// Combinational 8-bit subtractor: difference = minuend - subtrahend - borrow_i,
// with every slice-internal borrow computed directly from generate/propagate terms.
module borrow_lookahead_subtractor_8b
  import arith_pkg::*;
(
  input  logic [BYTE_W-1:0] minuend_i,
  input  logic [BYTE_W-1:0] subtrahend_i,
  input  logic              borrow_i,
  output logic [BYTE_W-1:0] difference_o,
  output logic              borrow_o
);

  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W:0]   borrow;

  assign gen  = ~minuend_i & subtrahend_i;
  assign prop = ~(minuend_i ^ subtrahend_i);

  // Borrow into bit i+1 is a flat sum of products over gen/prop of bits 0..i.
  always_comb begin : lookahead
    logic acc;
    logic chain;
    acc       = 1'b0;
    chain     = 1'b1;
    borrow    = '0;
    borrow[0] = borrow_i;
    for (int i = 0; i < BYTE_W; i++) begin
      acc   = 1'b0;
      chain = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc   = acc | (chain & gen[j]);
        chain = chain & prop[j];
      end
      borrow[i+1] = acc | (chain & borrow_i);
    end
  end

  assign difference_o = minuend_i ^ subtrahend_i ^ borrow[BYTE_W-1:0];
  assign borrow_o     = borrow[BYTE_W];

endmodule

// File: rtl/byte_serial_subtractor.sv
// WIDTH-bit subtractor that processes one byte slice per clock, LSB first,
// through a single shared lookahead slice, with valid/ready on both sides.
module byte_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] difference_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int NSLICE = WIDTH / BYTE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  sub_state_t        state_q;
  sub_state_t        state_d;
  logic [CNT_W-1:0]  slice_q;
  logic [WIDTH-1:0]  minuend_q;
  logic [WIDTH-1:0]  subtrahend_q;
  logic [WIDTH-1:0]  diff_q;
  logic [WIDTH-1:0]  diff_d;
  logic              borrow_q;
  logic              borrow_out_q;
  logic              overflow_q;
  logic              zero_q;

  logic [BYTE_W-1:0] slice_a;
  logic [BYTE_W-1:0] slice_b;
  logic [BYTE_W-1:0] slice_diff;
  logic              slice_borrow;

  logic accept;
  logic last_slice;
  logic result_taken;

  assign ready_o      = (state_q == IDLE);
  assign valid_o      = (state_q == DONE);
  assign accept       = valid_i && ready_o;
  assign result_taken = valid_o && ready_i;
  assign last_slice   = (state_q == RUN) && (slice_q == LAST_SLICE);

  assign slice_a = minuend_q[int'(slice_q)*BYTE_W +: BYTE_W];
  assign slice_b = subtrahend_q[int'(slice_q)*BYTE_W +: BYTE_W];

  borrow_lookahead_subtractor_8b u_slice (
    .minuend_i    (slice_a),
    .subtrahend_i (slice_b),
    .borrow_i     (borrow_q),
    .difference_o (slice_diff),
    .borrow_o     (slice_borrow)
  );

  // Difference with the current slice merged in; the flags are taken from this
  // on the final slice so they agree with the value latched into diff_q.
  always_comb begin
    diff_d = diff_q;
    diff_d[int'(slice_q)*BYTE_W +: BYTE_W] = slice_diff;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = RUN;
      RUN:     if (last_slice)   state_d = DONE;
      DONE:    if (result_taken) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // The counter parks on the last slice rather than wrapping; accept reloads it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slice_q      <= '0;
      minuend_q    <= '0;
      subtrahend_q <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else if (accept) begin
      minuend_q    <= minuend_i;
      subtrahend_q <= subtrahend_i;
      borrow_q     <= borrow_i;
      slice_q      <= '0;
      diff_q       <= '0;
    end else if (state_q == RUN) begin
      diff_q   <= diff_d;
      borrow_q <= slice_borrow;
      if (last_slice) begin
        borrow_out_q <= slice_borrow;
        overflow_q   <= (minuend_q[WIDTH-1] != subtrahend_q[WIDTH-1]) &&
                        (diff_d[WIDTH-1] != minuend_q[WIDTH-1]);
        zero_q       <= ~|diff_d;
      end else begin
        slice_q <= slice_q + 1'b1;
      end
    end
  end

  assign difference_o = diff_q;
  assign borrow_o     = borrow_out_q;
  assign overflow_o   = overflow_q;
  assign zero_o       = zero_q;

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Self-checking bench for byte_serial_subtractor: table vectors and random vectors
// through a scoreboard queue, plus backpressure, busy and mid-run reset sequences.
module tb_byte_serial_subtractor;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        borrow_in;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] difference;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  int   tests_run  = 0;
  int   fail_count = 0;
  vec_t sb[$];
  vec_t vecs[9];

  byte_serial_subtractor #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .minuend_i    (minuend),
    .subtrahend_i (subtrahend),
    .borrow_i     (borrow_in),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .difference_o (difference),
    .borrow_o     (borrow_out),
    .overflow_o   (overflow),
    .zero_o       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    vec_t        v;
    logic [32:0] full;
    full   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    v.a    = a;
    v.b    = b;
    v.bin  = bin;
    v.diff = full[31:0];
    v.bout = full[32];
    v.ovf  = (a[31] != b[31]) && (full[31] != a[31]);
    v.zero = (full[31:0] == 32'd0);
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits for ready_o at a falling edge, drives one accept, and returns at the
  // falling edge right after the accept edge with valid_i dropped.
  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    @(negedge clk);
    while (!ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkVal("ready_before_accept", {31'd0, ready_o}, 32'd1);
    minuend    = v.a;
    subtrahend = v.b;
    borrow_in  = v.bin;
    valid_i    = 1'b1;
    @(posedge clk);
    sb.push_back(v);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int exp_lat, input int hold_cycles);
    int   cyc = 0;
    vec_t e;
    while (!valid_o && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checkVal({tag, "_latency"}, cyc, exp_lat);
    checkVal({tag, "_ready_low"}, {31'd0, ready_o}, 32'd0);
    if (sb.size() == 0) begin
      checkVal({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int h = 0; h < hold_cycles; h++) begin
        checkVal({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
        checkVal({tag, "_hold_diff"}, difference, e.diff);
        @(negedge clk);
      end
      checkVal({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      checkVal({tag, "_diff"}, difference, e.diff);
      checkVal({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, e.bout});
      checkVal({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
      checkVal({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
    end
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    checkVal({tag, "_valid_after_take"}, {31'd0, valid_o}, 32'd0);
    checkVal({tag, "_ready_after_take"}, {31'd0, ready_o}, 32'd1);
    if (sb.size() == 0 && e.a == minuend) begin
      checkVal({tag, "_diff_kept"}, difference, e.diff);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1234_5677, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    borrow_in  = 1'b0;

    repeat (2) @(negedge clk);
    checkVal("reset_ready", {31'd0, ready_o}, 32'd1);
    checkVal("reset_valid", {31'd0, valid_o}, 32'd0);
    checkVal("reset_diff", difference, 32'd0);
    checkVal("reset_flags", {29'd0, borrow_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), 4, 0);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(model($urandom, $urandom, 1'($urandom_range(0, 1))));
      checkOutput($sformatf("rand%0d", i), 4, 0);
    end

    // Backpressure: result held for 5 cycles with ready_i low.
    applyStimulus(model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1));
    checkOutput("backpressure", 4, 5);

    // Busy: a new request during RUN must be ignored.
    applyStimulus(model(32'h0000_1000, 32'h0000_0FFF, 1'b0));
    minuend    = 32'h5555_5555;
    subtrahend = 32'h1111_1111;
    valid_i    = 1'b1;
    checkVal("busy_ready_low", {31'd0, ready_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    checkOutput("busy", 3, 0);

    // Reset two slices into a run discards the partial result.
    applyStimulus(model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkVal("midreset_valid", {31'd0, valid_o}, 32'd0);
    checkVal("midreset_ready", {31'd0, ready_o}, 32'd1);
    checkVal("midreset_diff", difference, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("postreset_ready", {31'd0, ready_o}, 32'd1);
    checkVal("postreset_valid", {31'd0, valid_o}, 32'd0);
    applyStimulus('{32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0});
    checkOutput("after_reset", 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
